// File: rtl/sram2s_pkg.sv
// Shared constants for the two-port masked-write SRAM and its read output stages.
package sram2s_pkg;

  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 2;
  // Port whose write mask wins, bit by bit, on a same-address double write
  localparam int COLL_PRIO_PORT = 1;

endpackage

// File: rtl/sram2s_rd_pipe.sv
// One port's read output stage: access-valid tracking, optional second register,
// hold-last-value on idle cycles, and flush of in-flight reads on reset.
module sram2s_rd_pipe
  import sram2s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              acc,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] q,
  output logic              qv
);

  logic v1_reg;

  always_ff @(posedge CLK) begin
    if (RST) v1_reg <= 1'b0;
    else     v1_reg <= acc;
  end

  generate
    if (READ_LAT == RD_LAT_MAX) begin : g_stage2
      logic [DATA_W-1:0] q2_reg;
      logic              qv2_reg;

      // Only a valid result moves forward, so idle cycles keep the last word
      always_ff @(posedge CLK) begin
        if (RST) begin
          q2_reg  <= '0;
          qv2_reg <= 1'b0;
        end else begin
          qv2_reg <= v1_reg;
          if (v1_reg) q2_reg <= rd_data;
        end
      end

      assign q  = q2_reg;
      assign qv = qv2_reg;
    end else begin : g_stage1
      assign q  = rd_data;
      assign qv = v1_reg;
    end
  endgenerate

endmodule

// File: rtl/sram2s_param.sv
// Two-port read-first SRAM with per-bit write masks and port-1 write priority.
// Define SRAM2S_COLLISION_CHK_EN to build the write-write collision detector.
module sram2s_param
  import sram2s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8192,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  output logic [DATA_W-1:0] Q0,
  output logic              QV0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] D1,
  input  logic              WE1,
  input  logic [DATA_W-1:0] WEM1,
  output logic [DATA_W-1:0] Q1,
  output logic              QV1,
  output logic              COLL,
  output logic              COLL_ERR
);

  localparam int HI_PORT = COLL_PRIO_PORT;
  localparam int LO_PORT = 1 - COLL_PRIO_PORT;

  generate
    if (READ_LAT < RD_LAT_MIN || READ_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("sram2s_param: READ_LAT must be 1 or 2");
    end
    if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
      $error("sram2s_param: DEPTH does not fit in ADDR_W bits");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]             ce;
  logic [1:0]             we;
  logic [1:0]             in_rng;
  logic [1:0]             wr_en;
  logic [1:0]             qv;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdat;
  logic [1:0][DATA_W-1:0] wmsk;
  logic [1:0][DATA_W-1:0] q;

  assign ce   = {CE1, CE0};
  assign we   = {WE1, WE0};
  assign addr = {A1, A0};
  assign wdat = {D1, D0};
  assign wmsk = {WEM1, WEM0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rd_data_reg;

      assign in_rng[gi] = 64'(addr[gi]) < 64'(DEPTH);
      assign wr_en[gi]  = ce[gi] & we[gi] & in_rng[gi] & ~RST;

      // Array output register; reads see pre-write contents of this edge
      always_ff @(posedge CLK) begin
        if (RST)
          rd_data_reg <= '0;
        else if (ce[gi])
          rd_data_reg <= in_rng[gi] ? mem[addr[gi]] : '0;
      end

      sram2s_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
      ) u_rd_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .acc     (ce[gi]),
        .rd_data (rd_data_reg),
        .q       (q[gi]),
        .qv      (qv[gi])
      );
    end
  endgenerate

  assign Q0  = q[0];
  assign Q1  = q[1];
  assign QV0 = qv[0];
  assign QV1 = qv[1];

  // Priority port is written last so its masked bits override on a shared address
  always_ff @(posedge CLK) begin
    for (int b = 0; b < DATA_W; b++) begin
      if (wr_en[LO_PORT] && wmsk[LO_PORT][b])
        mem[addr[LO_PORT]][b] <= wdat[LO_PORT][b];
    end
    for (int b = 0; b < DATA_W; b++) begin
      if (wr_en[HI_PORT] && wmsk[HI_PORT][b])
        mem[addr[HI_PORT]][b] <= wdat[HI_PORT][b];
    end
  end

`ifdef SRAM2S_COLLISION_CHK_EN
  logic coll_next;
  logic coll_reg;
  logic coll_err_reg;

  assign coll_next = wr_en[0] & wr_en[1] & (addr[0] == addr[1]) & (|(wmsk[0] & wmsk[1]));

  always_ff @(posedge CLK) begin
    if (RST) begin
      coll_reg     <= 1'b0;
      coll_err_reg <= 1'b0;
    end else begin
      coll_reg     <= coll_next;
      coll_err_reg <= coll_err_reg | coll_next;
    end
  end

  assign COLL     = coll_reg;
  assign COLL_ERR = coll_err_reg;
`else
  assign COLL     = 1'b0;
  assign COLL_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sram2s_param.sv
// Randomized self-checking bench for sram2s_param (DEPTH=6000, READ_LAT=2) against
// a cycle-indexed behavioural model; honours SRAM2S_COLLISION_CHK_EN if defined.
module tb_sram2s_param;

  localparam int DW  = 16;
  localparam int DEP = 6000;
  localparam int AW  = 13;
  localparam int LAT = 2;
  localparam int NE  = 4096;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CE0 = 1'b0, WE0 = 1'b0, CE1 = 1'b0, WE1 = 1'b0;
  logic [AW-1:0] A0 = '0, A1 = '0;
  logic [DW-1:0] D0 = '0, D1 = '0, WEM0 = '0, WEM1 = '0;
  logic [DW-1:0] Q0, Q1;
  logic          QV0, QV1, COLL, COLL_ERR;

  always #5 CLK = ~CLK;

  sram2s_param #(
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .ADDR_W   (AW),
    .READ_LAT (LAT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .Q0(Q0), .QV0(QV0),
    .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(Q1), .QV1(QV1),
    .COLL(COLL), .COLL_ERR(COLL_ERR)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: memory image plus, per edge number, what each port's access returned
  logic [DW-1:0] ref_mem [DEP];
  bit            hv0 [NE];
  bit            hv1 [NE];
  logic [DW-1:0] hd0 [NE];
  logic [DW-1:0] hd1 [NE];
  int            ecnt     = -1;
  int            last_rst = -1;
  logic [DW-1:0] held0 = '0, held1 = '0;
  logic          exp_qv0 = 1'b0, exp_qv1 = 1'b0, exp_coll = 1'b0, exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  function automatic bit in_rng(input logic [AW-1:0] a);
    return int'(a) < DEP;
  endfunction

  task automatic model_edge();
    bit w0, w1, coll;
    int src;
    coll = 1'b0;
    ecnt++;
    if (ecnt >= NE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", ecnt, NE);
      $fatal(1, "edge budget exhausted");
    end
    if (RST) begin
      last_rst  = ecnt;
      held0     = '0;
      held1     = '0;
      exp_err   = 1'b0;
      hv0[ecnt] = 1'b0;
      hv1[ecnt] = 1'b0;
    end else begin
      hv0[ecnt] = CE0;
      hv1[ecnt] = CE1;
      hd0[ecnt] = (CE0 && in_rng(A0)) ? ref_mem[A0] : '0;
      hd1[ecnt] = (CE1 && in_rng(A1)) ? ref_mem[A1] : '0;
      w0 = CE0 && WE0 && in_rng(A0);
      w1 = CE1 && WE1 && in_rng(A1);
      if (w0) ref_mem[A0] = (ref_mem[A0] & ~WEM0) | (D0 & WEM0);
      if (w1) ref_mem[A1] = (ref_mem[A1] & ~WEM1) | (D1 & WEM1);
      coll = w0 && w1 && (A0 == A1) && ((WEM0 & WEM1) != '0);
    end
`ifdef SRAM2S_COLLISION_CHK_EN
    exp_coll = coll;
    exp_err  = exp_err | coll;
`else
    exp_coll = 1'b0;
    exp_err  = 1'b0;
`endif
    // A result sampled at edge s is visible after edge s+LAT-1 unless a reset intervened
    src = ecnt - LAT + 1;
    exp_qv0 = 1'b0;
    exp_qv1 = 1'b0;
    if (src >= 0 && src > last_rst) begin
      if (hv0[src]) begin exp_qv0 = 1'b1; held0 = hd0[src]; end
      if (hv1[src]) begin exp_qv1 = 1'b1; held1 = hd1[src]; end
    end
  endtask

  task automatic check_outputs();
    check_eq("qv0", QV0, exp_qv0);
    check_eq("q0", Q0, held0);
    check_eq("qv1", QV1, exp_qv1);
    check_eq("q1", Q1, held1);
    check_eq("coll", COLL, exp_coll);
    check_eq("coll_err", COLL_ERR, exp_err);
  endtask

  task automatic cycle(input bit rst,
                       input bit ce0, input bit we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic [DW-1:0] m0,
                       input bit ce1, input bit we1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [DW-1:0] m1);
    RST = rst;
    CE0 = ce0; WE0 = we0; A0 = a0; D0 = d0; WEM0 = m0;
    CE1 = ce1; WE1 = we1; A1 = a1; D1 = d1; WEM1 = m1;
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    cycle(0, 1, 0, a, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    cycle(0, 1, 1, a, d, m, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Give addresses 0..31 known contents
    for (int i = 0; i < 16; i++)
      cycle(0, 1, 1, AW'(i), DW'($urandom), 16'hFFFF, 1, 1, AW'(i + 16), DW'($urandom), 16'hFFFF);

    // Masked write over 16'h1234
    wr0(5, 16'h1234, 16'hFFFF);
    wr0(5, 16'hFFFF, 16'h00FF);
    rd0(5);
    idle();
    check_eq("masked_q0", Q0, 16'h12FF);
    check_eq("masked_qv0", QV0, 1'b1);

    // Read-first across ports
    wr0(7, 16'h0001, 16'hFFFF);
    cycle(0, 1, 1, 7, 16'hAAAA, 16'hFFFF, 1, 0, 7, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
    check_eq("rdfirst_old", Q1, 16'h0001);
    idle();
    check_eq("rdfirst_new", Q1, 16'hAAAA);

    // Same-address double write
    cycle(0, 1, 1, 3, 16'h1111, 16'hFFFF, 1, 1, 3, 16'h2222, 16'h0F0F);
`ifdef SRAM2S_COLLISION_CHK_EN
    check_eq("coll_pulse", COLL, 1'b1);
`endif
    idle();
    rd0(3);
    idle();
    check_eq("coll_merge", Q0, 16'h1212);

    // Back-to-back reads then idle hold
    rd0(0); rd0(1); rd0(2);
    idle(); idle(); idle();
    check_eq("hold_q0", Q0, ref_mem[2]);
    check_eq("hold_qv0", QV0, 1'b0);

    // Reset while a read is in flight and a write is presented
    wr0(9, 16'h0909, 16'hFFFF);
    rd0(5);
    cycle(1, 0, 0, 0, 0, 0, 1, 1, 9, 16'hBEEF, 16'hFFFF);
    check_eq("rst_q0", Q0, 16'h0000);
    idle();
    check_eq("rst_flush_qv0", QV0, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0);
    idle();
    check_eq("rst_nowrite", Q1, 16'h0909);

    // Out-of-range access
    wr0(6500, 16'hDEAD, 16'hFFFF);
    rd0(6500);
    idle();
    check_eq("oor_q0", Q0, 16'h0000);
    check_eq("oor_qv0", QV0, 1'b1);

    // Random traffic, occasional collisions and resets
    for (int n = 0; n < 2000; n++) begin
      logic [AW-1:0] ra0, ra1;
      ra0 = ($urandom_range(9) == 0) ? AW'(6000 + $urandom_range(2191)) : AW'($urandom_range(31));
      ra1 = ($urandom_range(9) == 0) ? AW'(6000 + $urandom_range(2191)) : AW'($urandom_range(31));
      if ($urandom_range(7) == 0) ra1 = ra0;
      cycle($urandom_range(63) == 0,
            $urandom_range(3) != 0, $urandom_range(1) == 1, ra0, DW'($urandom), DW'($urandom),
            $urandom_range(3) != 0, $urandom_range(1) == 1, ra1, DW'($urandom), DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram2s_param.md
SRAM2S_PARAM -- requirements
Module: sram2s_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8192, number of words.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 The block SHALL have parameter READ_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-005 The block SHALL have port CLK, input, 1, the single clock, rising edge.
REQ-006 The block SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-007 For each port p in {0,1}, the block SHALL have the following signals: CEp input 1 (access enable); Ap input ADDR_W (address); Dp input DATA_W (write data); WEp input 1 (write enable); WEMp input DATA_W (per-bit write mask, 1=write); Qp output DATA_W (read data); QVp output 1 (Qp valid).
REQ-008 The block SHALL have port COLL, output, 1, a one-cycle pulse on write-write collision.
REQ-009 The block SHALL have port COLL_ERR, output, 1, a sticky collision flag.

Function
REQ-010 An access on port p SHALL occur when CEp=1 and RST=0; Ap values of DEPTH or above SHALL be ignored for writes and SHALL return 0 on reads.
REQ-011 The write condition SHALL be CEp&WEp; only bits with WEMp=1 SHALL be updated, and all other bits SHALL retain their old value.
REQ-012 Reads SHALL be read-first: Qp returns the array content from before any write in the same cycle, on either port.
REQ-013 With READ_LAT=1, Qp/QVp SHALL update at the edge that samples the access; with READ_LAT=2, they SHALL update one edge later through an extra register stage.
REQ-014 QVp SHALL be 1 exactly READ_LAT cycles after each access with CEp=1 (read or write), and 0 otherwise.
REQ-015 When no valid result emerges, Qp SHALL hold its last value and SHALL never go X.
REQ-016 For a same-address write on both ports in one cycle, the bitwise result SHALL be: bits with WEM1=1 take D1; else bits with WEM0=1 take D0; else the old value. Port 1 has priority.
REQ-017 Each port SHALL accept a new access every cycle, with no back-pressure.

Reset
REQ-018 When RST=1 at an edge, Q0, Q1, QV0, QV1, COLL and COLL_ERR SHALL all clear to 0, and the read pipeline stages SHALL clear.
REQ-019 Array contents SHALL NOT be reset, and writes presented in a cycle with RST=1 SHALL be suppressed.
REQ-020 Reads in flight when RST asserts SHALL be discarded: no QVp pulse for them after reset releases.

Configuration
REQ-021 With macro SRAM2S_COLLISION_CHK_EN defined, COLL SHALL pulse 1 cycle after an edge where both ports wrote the same in-range address with (WEM0&WEM1)!=0, and COLL_ERR SHALL set at that time and hold until RST.
REQ-022 Without SRAM2S_COLLISION_CHK_EN, COLL and COLL_ERR SHALL be constant 0 and no detection logic SHALL be synthesised; REQ-016 priority SHALL still apply.

Structure
REQ-023 Package sram2s_pkg SHALL hold the READ_LAT legal-value constants (RD_LAT_MIN=1, RD_LAT_MAX=2) and the collision-priority constant COLL_PRIO_PORT=1.
REQ-024 Sub-module sram2s_rd_pipe SHALL implement one port's output stage (optional second register, QV tracking, hold-last, reset flush) and SHALL be instantiated twice.
REQ-025 Elaboration SHALL fail if READ_LAT is not 1 or 2, or if DEPTH > 2**ADDR_W.

Verification
REQ-026 Masked write: A0=5, D0=16'hFFFF, WEM0=16'h00FF over old value 16'h1234, then read A0=5 -> Q0=16'h12FF with QV0=1 after READ_LAT cycles.
REQ-027 Read-first: port0 writes 16'hAAAA to addr 7 (old value 16'h0001) while port1 reads addr 7 in the same cycle -> Q1=16'h0001; next port1 read -> 16'hAAAA.
REQ-028 Collision: both ports write addr 3 with D0=16'h1111/WEM0=16'hFFFF and D1=16'h2222/WEM1=16'h0F0F -> mem[3]=16'h1212; with macro defined, COLL pulses once and COLL_ERR stays 1 until RST.
REQ-029 Latency: READ_LAT=2, back-to-back reads of addrs 0,1,2 -> QV0 high for 3 consecutive cycles starting 2 cycles after the first read, with data in order and CE0=0 afterwards holding Q0 at the last value.
REQ-030 Reset mid-operation: assert RST in the cycle after a read with READ_LAT=2 that overlaps a write to addr 9 -> no QV pulse, Q=0, and mem[9] unchanged.
REQ-031 Out-of-range: DEPTH=6000, write to A0=6500 -> no array change; read of A0=6500 -> Q0=0 with QV0=1.
